datapath_elastic: RTL

DATAPATH_ELASTIC -- requirements
Module: datapath_elastic

---
 rtl/datapath_elastic.sv | 126 ++++++++++++
 1 files changed

// File: rtl/datapath_elastic.sv
// Elastic add/subtract datapath: the result is computed at the input, then carried through
// STAGES valid/ready register stages with an overflow sticky flag at the output.
module datapath_elastic #(
   parameter int unsigned N      = 16,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [2:0]   opcode,
   input  logic         sat,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] Y,
   output logic         co,
   output logic         ov,
   output logic         zero,
   output logic         neg,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         ov_sticky,
   input  logic         ov_clr
);

   localparam int unsigned Last = STAGES - 1;

   logic [N-1:0] op2, op2x, res_y;
   logic [N:0]   sum;
   logic         res_ov;

   always_comb begin
      op2    = opcode[2] ? '0 : B;
      op2x   = opcode[1] ? ~op2 : op2;
      sum    = {1'b0, A} + {1'b0, op2x} + {{N{1'b0}}, opcode[0]};
      res_ov = (A[N-1] == op2x[N-1]) && (sum[N-1] != A[N-1]);
      if (sat && res_ov) begin
         res_y = A[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end else begin
         res_y = sum[N-1:0];
      end
   end

   logic [STAGES-1:0] vld_q, co_q, ov_q, zero_q, neg_q;
   logic [N-1:0]      y_q [STAGES];

   logic [STAGES-1:0] src_vld, src_co, src_ov, src_zero, src_neg;
   logic [N-1:0]      src_y [STAGES];
   logic [STAGES-1:0] ld;
   logic              full_above;

   // Stage 0 is fed by the freshly computed result; stage k by stage k-1.
   always_comb begin
      src_vld     = '0;
      src_co      = '0;
      src_ov      = '0;
      src_zero    = '0;
      src_neg     = '0;
      src_vld[0]  = in_valid;
      src_y[0]    = res_y;
      src_co[0]   = sum[N];
      src_ov[0]   = res_ov;
      src_zero[0] = (res_y == '0);
      src_neg[0]  = res_y[N-1];
      for (int k = 1; k < int'(STAGES); k++) begin
         src_vld[k]  = vld_q[k-1];
         src_y[k]    = y_q[k-1];
         src_co[k]   = co_q[k-1];
         src_ov[k]   = ov_q[k-1];
         src_zero[k] = zero_q[k-1];
         src_neg[k]  = neg_q[k-1];
      end
   end

   // A stage may load unless it and every stage after it are full while the output stalls.
   always_comb begin
      ld         = '0;
      full_above = 1'b1;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         full_above = full_above & vld_q[k];
         ld[k]      = out_ready | ~full_above;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q     <= '0;
         co_q      <= '0;
         ov_q      <= '0;
         zero_q    <= '0;
         neg_q     <= '0;
         ov_sticky <= 1'b0;
         for (int k = 0; k < int'(STAGES); k++) begin
            y_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(STAGES); k++) begin
            if (ld[k]) begin
               vld_q[k] <= src_vld[k];
               // Bubbles leave the payload untouched so stalled outputs stay stable.
               if (src_vld[k]) begin
                  y_q[k]    <= src_y[k];
                  co_q[k]   <= src_co[k];
                  ov_q[k]   <= src_ov[k];
                  zero_q[k] <= src_zero[k];
                  neg_q[k]  <= src_neg[k];
               end
            end
         end
         if (vld_q[Last] && out_ready && ov_q[Last]) begin
            ov_sticky <= 1'b1;
         end else if (ov_clr) begin
            ov_sticky <= 1'b0;
         end
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = vld_q[Last];
   assign Y         = y_q[Last];
   assign co        = co_q[Last];
   assign ov        = ov_q[Last];
   assign zero      = zero_q[Last];
   assign neg       = neg_q[Last];

endmodule
